// File: rtl/register_file_mp_pkg.sv
// Shared defaults, datapath typedefs and address helper for the register file.
package regfile_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int NUM_RD_DEF   = 2;
  localparam int ZERO_REG_DEF = 1;
  localparam int BYPASS_DEF   = 1;
  localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

  typedef logic [DATA_W_DEF-1:0] data_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

  // An address can hold a value only if it exists and is not the hardwired zero register.
  function automatic logic addr_writable(input int a, input int nregs, input int zero_reg);
    return (a < nregs) && !((zero_reg != 0) && (a == 0));
  endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Decode/writeback bus of the register file: read ports, two write ports, reservations.
interface register_file_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = NUM_RD_DEF
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wa_en;
  logic [ADDR_W-1:0]        wa_addr;
  logic [DATA_W-1:0]        wa_data;
  logic                     wb_en;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_data;
  logic                     wr_conflict;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     rsv_ok;
  logic [NUM_REGS-1:0]      busy_vec;

  modport master (
    output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, wr_conflict, rsv_ok, busy_vec
  );

  modport slave (
    input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, wr_conflict, rsv_ok, busy_vec
  );

endinterface

// File: rtl/register_file_mp_scoreboard.sv
// Per-register busy tracking: reservations set, committed writebacks clear, reserve wins a tie.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF,
  parameter int BYPASS   = BYPASS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     commit_a,
  input  logic [ADDR_W-1:0]        commit_a_addr,
  input  logic                     commit_b,
  input  logic [ADDR_W-1:0]        commit_b_addr,
  output logic                     rsv_ok,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [NUM_REGS-1:0]      busy_vec
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  // Padded to the full address space so out-of-range addresses read as not busy.
  logic [DEPTH-1:0]    busy_ext;
  logic                rsv_take;

  function automatic logic wr_hit(input logic [ADDR_W-1:0] a, input logic ca,
                                  input logic [ADDR_W-1:0] caa, input logic cb,
                                  input logic [ADDR_W-1:0] cba);
    return (ca && (caa == a)) || (cb && (cba == a));
  endfunction

  assign busy_ext = DEPTH'(busy_q);
  assign busy_vec = busy_q;

  // Held high in reset; otherwise a free register, or one being written back this cycle.
  assign rsv_ok = !rst_n ||
                  ((int'(rsv_addr) < NUM_REGS) &&
                   (!busy_ext[rsv_addr] ||
                    wr_hit(rsv_addr, commit_a, commit_a_addr, commit_b, commit_b_addr)));

  // The zero register accepts a reservation but never records it.
  assign rsv_take = rst_n && rsv_en && rsv_ok &&
                    addr_writable(int'(rsv_addr), NUM_REGS, ZERO_REG);

  // Next busy vector: clear on writeback, then set on reservation so a new producer wins.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (wr_hit(ADDR_W'(r), commit_a, commit_a_addr, commit_b, commit_b_addr))
        busy_d[r] = 1'b0;
      if (rsv_take && (rsv_addr == ADDR_W'(r)))
        busy_d[r] = 1'b1;
    end
  end

  // Busy vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd_busy
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[gi*ADDR_W +: ADDR_W];
    assign rd_busy[gi] = busy_ext[a] &&
                         !((BYPASS != 0) &&
                           wr_hit(a, commit_a, commit_a_addr, commit_b, commit_b_addr));
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: storage, A-over-B write priority, read ports with optional bypass.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF,
  parameter int BYPASS   = BYPASS_DEF
) (
  input logic               clk,
  input logic               rst_n,
  register_file_mp_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic              commit_a;
  logic              commit_b;
  logic              same_addr;

  assign same_addr = (bus.wa_addr == bus.wb_addr);
  assign commit_a  = rst_n && bus.wa_en &&
                     addr_writable(int'(bus.wa_addr), NUM_REGS, ZERO_REG);
  assign commit_b  = rst_n && bus.wb_en &&
                     addr_writable(int'(bus.wb_addr), NUM_REGS, ZERO_REG) &&
                     !(commit_a && same_addr);
  assign bus.wr_conflict = commit_a && bus.wb_en && same_addr;

  // Storage update; port A takes the register when both ports target it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) mem_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (commit_a && (bus.wa_addr == ADDR_W'(r)))      mem_q[r] <= bus.wa_data;
        else if (commit_b && (bus.wb_addr == ADDR_W'(r))) mem_q[r] <= bus.wb_data;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] val;
    assign a = bus.rd_addr[gi*ADDR_W +: ADDR_W];

    // Read mux: zero for non-storage addresses, else stored value with optional forwarding.
    always_comb begin
      val = '0;
      if (addr_writable(int'(a), NUM_REGS, ZERO_REG)) begin
        val = mem_q[a];
        if (BYPASS != 0) begin
          if (commit_b && (bus.wb_addr == a)) val = bus.wb_data;
          if (commit_a && (bus.wa_addr == a)) val = bus.wa_data;
        end
      end
    end

    assign bus.rd_data[gi*DATA_W +: DATA_W] = val;
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_addr       (bus.rd_addr),
    .rsv_en        (bus.rsv_en),
    .rsv_addr      (bus.rsv_addr),
    .commit_a      (commit_a),
    .commit_a_addr (bus.wa_addr),
    .commit_b      (commit_b),
    .commit_b_addr (bus.wb_addr),
    .rsv_ok        (bus.rsv_ok),
    .rd_busy       (bus.rd_busy),
    .busy_vec      (bus.busy_vec)
  );

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: default instance (zero reg, bypass) and a 24-deep, no-bypass instance.
module tb_register_file_mp;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       wa_en, wb_en, rsv_en;
  logic [4:0] wa_addr, wb_addr, rsv_addr, ra0, ra1;
  data_t      wa_data, wb_data;

  register_file_mp_if                 if0();
  register_file_mp_if #(.NUM_REGS(24)) if1();

  assign if0.rd_addr = {ra1, ra0};  assign if1.rd_addr = {ra1, ra0};
  assign if0.wa_en = wa_en;         assign if1.wa_en = wa_en;
  assign if0.wa_addr = wa_addr;     assign if1.wa_addr = wa_addr;
  assign if0.wa_data = wa_data;     assign if1.wa_data = wa_data;
  assign if0.wb_en = wb_en;         assign if1.wb_en = wb_en;
  assign if0.wb_addr = wb_addr;     assign if1.wb_addr = wb_addr;
  assign if0.wb_data = wb_data;     assign if1.wb_data = wb_data;
  assign if0.rsv_en = rsv_en;       assign if1.rsv_en = rsv_en;
  assign if0.rsv_addr = rsv_addr;   assign if1.rsv_addr = rsv_addr;

  register_file_mp dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  register_file_mp #(.NUM_REGS(24), .ZERO_REG(0), .BYPASS(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  logic [63:0] o_rd [2];
  logic [1:0]  o_rb [2];
  logic        o_cf [2];
  logic        o_ok [2];
  logic [31:0] o_bv [2];
  assign o_rd[0] = if0.rd_data;      assign o_rd[1] = if1.rd_data;
  assign o_rb[0] = if0.rd_busy;      assign o_rb[1] = if1.rd_busy;
  assign o_cf[0] = if0.wr_conflict;  assign o_cf[1] = if1.wr_conflict;
  assign o_ok[0] = if0.rsv_ok;       assign o_ok[1] = if1.rsv_ok;
  assign o_bv[0] = if0.busy_vec;     assign o_bv[1] = {8'b0, if1.busy_vec};

  // Reference model: architectural contents and busy flags per instance configuration.
  logic [31:0] m_mem  [2][32];
  bit          m_busy [2][32];
  int          cfg_nr [2] = '{32, 24};
  int          cfg_zr [2] = '{1, 0};
  int          cfg_bp [2] = '{1, 0};
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_wr(int k, int a);
    return (a < cfg_nr[k]) && !(cfg_zr[k] != 0 && a == 0);
  endfunction
  function automatic bit m_ca(int k);
    return rst_n && wa_en && m_wr(k, int'(wa_addr));
  endfunction
  function automatic bit m_cb(int k);
    return rst_n && wb_en && m_wr(k, int'(wb_addr)) && !(m_ca(k) && wa_addr == wb_addr);
  endfunction
  function automatic bit m_hit(int k, int a);
    return (m_ca(k) && int'(wa_addr) == a) || (m_cb(k) && int'(wb_addr) == a);
  endfunction
  function automatic logic [31:0] m_read(int k, int a);
    if (!m_wr(k, a)) return 32'h0;
    if (cfg_bp[k] != 0 && m_ca(k) && int'(wa_addr) == a) return wa_data;
    if (cfg_bp[k] != 0 && m_cb(k) && int'(wb_addr) == a) return wb_data;
    return m_mem[k][a];
  endfunction
  function automatic bit m_rbusy(int k, int a);
    if (!m_wr(k, a)) return 1'b0;
    if (cfg_bp[k] != 0 && m_hit(k, a)) return 1'b0;
    return m_busy[k][a];
  endfunction
  function automatic bit m_rsvok(int k);
    int a = int'(rsv_addr);
    if (!rst_n) return 1'b1;
    if (a >= cfg_nr[k]) return 1'b0;
    if (cfg_zr[k] != 0 && a == 0) return 1'b1;
    return !m_busy[k][a] || m_hit(k, a);
  endfunction
  function automatic bit m_conf(int k);
    return rst_n && wa_en && wb_en && wa_addr == wb_addr && m_wr(k, int'(wa_addr));
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 32; r++) begin m_mem[k][r] = '0; m_busy[k][r] = 1'b0; end
  endtask

  task automatic m_update(int k);
    bit take = rsv_en && m_rsvok(k) && m_wr(k, int'(rsv_addr));
    bit ca = m_ca(k);
    bit cb = m_cb(k);
    if (cb) begin m_mem[k][wb_addr] = wb_data; m_busy[k][wb_addr] = 1'b0; end
    if (ca) begin m_mem[k][wa_addr] = wa_data; m_busy[k][wa_addr] = 1'b0; end
    if (take) m_busy[k][rsv_addr] = 1'b1;
  endtask

  task automatic compare_all();
    logic [31:0] bv;
    for (int k = 0; k < 2; k++) begin
      bv = '0;
      for (int r = 0; r < cfg_nr[k]; r++) bv[r] = m_busy[k][r];
      chk($sformatf("rd0_d%0d_a%0d", k, ra0), {32'h0, o_rd[k][31:0]}, {32'h0, m_read(k, int'(ra0))});
      chk($sformatf("rd1_d%0d_a%0d", k, ra1), {32'h0, o_rd[k][63:32]}, {32'h0, m_read(k, int'(ra1))});
      chk($sformatf("rbusy0_d%0d", k), {63'h0, o_rb[k][0]}, {63'h0, m_rbusy(k, int'(ra0))});
      chk($sformatf("rbusy1_d%0d", k), {63'h0, o_rb[k][1]}, {63'h0, m_rbusy(k, int'(ra1))});
      chk($sformatf("conflict_d%0d", k), {63'h0, o_cf[k]}, {63'h0, m_conf(k)});
      chk($sformatf("rsv_ok_d%0d", k), {63'h0, o_ok[k]}, {63'h0, m_rsvok(k)});
      chk($sformatf("busy_vec_d%0d", k), {32'h0, o_bv[k]}, {32'h0, bv});
    end
  endtask

  // Called at a negedge: apply inputs, then check combinational outputs against the model.
  task automatic drive(input bit ea, input int aa, input logic [31:0] da,
                       input bit eb, input int ab, input logic [31:0] db,
                       input bit er, input int ar, input int r0, input int r1);
    wa_en = ea; wa_addr = 5'(aa); wa_data = da;
    wb_en = eb; wb_addr = 5'(ab); wb_data = db;
    rsv_en = er; rsv_addr = 5'(ar); ra0 = 5'(r0); ra1 = 5'(r1);
    #1 compare_all();
  endtask

  task automatic idle(input int r0, input int r1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, r0, r1);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin m_update(0); m_update(1); end
    @(negedge clk);
  endtask

  function automatic int pick();
    int hot [5] = '{0, 3, 7, 9, 30};
    if ($urandom_range(0, 1) == 0) return hot[$urandom_range(0, 4)];
    return int'($urandom_range(0, 31));
  endfunction

  initial begin
    rst_n = 1'b0;
    m_reset();
    idle(0, 0);
    repeat (2) @(negedge clk);
    idle(5, 9);
    rst_n = 1'b1;

    // Write A r3 with bypass vs. without
    drive(1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 3, 0);
    chk("t2_bypass_same_cycle", {32'h0, o_rd[0][31:0]}, 64'hDEADBEEF);
    chk("t2_nobypass_old", {32'h0, o_rd[1][31:0]}, 64'h0);
    tick();
    idle(3, 0);
    chk("t2_nobypass_next", {32'h0, o_rd[1][31:0]}, 64'hDEADBEEF);
    tick();

    // A and B to r7 on the same edge
    drive(1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 7, 0);
    chk("t3_conflict_d0", {63'h0, o_cf[0]}, 64'h1);
    chk("t3_conflict_d1", {63'h0, o_cf[1]}, 64'h1);
    tick();
    idle(7, 7);
    chk("t3_r7_d0", {32'h0, o_rd[0][31:0]}, 64'h11);
    chk("t3_r7_d1", {32'h0, o_rd[1][63:32]}, 64'h11);
    tick();

    // Zero register
    drive(1, 0, 32'hFFFFFFFF, 1, 0, 32'h1234, 1, 0, 0, 0);
    chk("t4_conflict_r0", {63'h0, o_cf[0]}, 64'h0);
    chk("t4_rsv_ok_r0", {63'h0, o_ok[0]}, 64'h1);
    tick();
    idle(0, 0);
    chk("t4_r0_reads_0", {32'h0, o_rd[0][31:0]}, 64'h0);
    chk("t4_busy0_clear", {63'h0, o_bv[0][0]}, 64'h0);
    tick();

    // Reservation / writeback on r9
    drive(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    chk("t5_busy9_set", {63'h0, o_bv[0][9]}, 64'h1);
    chk("t5_rerserve_refused", {63'h0, o_ok[0]}, 64'h0);
    chk("t5_rd_busy9", {63'h0, o_rb[0][0]}, 64'h1);
    tick();
    drive(0, 0, 0, 1, 9, 32'h5, 0, 0, 9, 0);
    chk("t5_rd_busy_bypassed", {63'h0, o_rb[0][0]}, 64'h0);
    tick();
    idle(9, 0);
    chk("t5_busy9_cleared", {63'h0, o_bv[0][9]}, 64'h0);
    chk("t5_r9_value", {32'h0, o_rd[0][31:0]}, 64'h5);
    tick();
    drive(1, 9, 32'h6, 0, 0, 0, 1, 9, 9, 0);
    tick();
    idle(9, 0);
    chk("t5_reserve_wins", {63'h0, o_bv[0][9]}, 64'h1);
    chk("t5_r9_new", {32'h0, o_rd[0][31:0]}, 64'h6);
    tick();

    // Out-of-range address on the 24-deep instance
    drive(1, 30, 32'hAAAA5555, 1, 30, 32'h1, 1, 30, 30, 30);
    chk("t6_rd_oob", {32'h0, o_rd[1][31:0]}, 64'h0);
    chk("t6_rd_busy_oob", {62'h0, o_rb[1]}, 64'h0);
    chk("t6_rsv_ok_oob", {63'h0, o_ok[1]}, 64'h0);
    chk("t6_conflict_oob", {63'h0, o_cf[1]}, 64'h0);
    tick();
    idle(30, 30);
    chk("t6_write_dropped", {32'h0, o_rd[1][31:0]}, 64'h0);
    tick();

    // Mid-run asynchronous reset
    drive(1, 5, 32'h55, 0, 0, 0, 1, 11, 5, 11);
    tick();
    rst_n = 1'b0;
    m_reset();
    drive(1, 5, 32'h77, 1, 6, 32'h66, 1, 12, 5, 11);
    chk("t1_rd_zero_d0", o_rd[0], 64'h0);
    chk("t1_rd_zero_d1", o_rd[1], 64'h0);
    chk("t1_busy_zero_d0", {32'h0, o_bv[0]}, 64'h0);
    chk("t1_busy_zero_d1", {32'h0, o_bv[1]}, 64'h0);
    tick();
    rst_n = 1'b1;
    idle(5, 5);
    chk("t1_r5_after_d0", {32'h0, o_rd[0][31:0]}, 64'h0);
    chk("t1_r5_after_d1", {32'h0, o_rd[1][31:0]}, 64'h0);
    tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), pick(), $urandom,
            1'($urandom_range(0, 1)), pick(), $urandom,
            1'($urandom_range(0, 1)), pick(), pick(), pick());
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
